// File: rtl/line_memory_if.sv
// Cache-to-memory line port: one request in, one acknowledged 256-bit line out.
// Signal names follow the memory's point of view (_i into the memory, _o out of it).
interface line_memory_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, busy_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, busy_o
  );
endinterface

// File: rtl/line_memory.sv
// Line-granular main memory behind the data cache: fixed-latency single-port
// line array with a captured request, a one-cycle ack pulse and a held read line.
module line_memory #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  line_memory_if.slave bus
);

  localparam int unsigned LINES      = 1 << DEPTH_LOG2;
  localparam logic [7:0]  COUNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_capture;
  logic                    w_access;
  logic [7:0]              r_count;
  logic                    r_write;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [255:0]            r_data;
  logic                    r_ack;
  logic [255:0]            r_rdata;
  logic [255:0]            r_mem [LINES];

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_access     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.enable_i) begin
          w_capture    = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_count == 8'd0) begin
          w_access     = 1'b1;
          w_next_state = ST_ACK;
        end
      end
      ST_ACK:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Request registers are loaded only in IDLE, so bus changes during a
  // request cannot disturb it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= 8'd0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_access;
      if (w_capture) begin
        r_count <= COUNT_LOAD;
        r_write <= bus.write_i;
        r_idx   <= bus.addr_i[DEPTH_LOG2+4:5];
        r_data  <= bus.data_i;
      end else if (r_state == ST_BUSY && r_count != 8'd0) begin
        r_count <= r_count - 8'd1;
      end
      if (w_access && !r_write) r_rdata <= r_mem[r_idx];
    end
  end

  // NOTE: the line array has no reset; its contents survive reset, and a
  // request cut short by reset never reaches the write because the FSM is
  // forced back to IDLE.
  always_ff @(posedge clk_i) begin
    if (w_access && r_write) r_mem[r_idx] <= r_data;
  end

  assign bus.ack_o  = r_ack;
  assign bus.data_o = r_rdata;
  assign bus.busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_line_memory.sv
// Directed and randomized bench for line_memory against a line-array model
// indexed by (address / 32) mod line count.
module tb_line_memory;
  localparam int L  = 10;
  localparam int DL = 9;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  line_memory_if bus ();

  line_memory #(.LATENCY(L), .DEPTH_LOG2(DL)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int           n_pass  = 0;
  int           n_total = 0;
  longint       cyc     = 0;
  logic [255:0] model [int];
  logic [255:0] last_rd = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd32) % (32'd1 << DL));
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle(input int n, input string tag);
    int acks = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.ack_o === 1'b1) acks++;
    end
    check(tag, acks, 0);
  endtask

  // Issues one request in the current (IDLE) cycle and returns in the IDLE
  // cycle LATENCY+2 later; ack_at is the global cycle of the ack pulse.
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                         input bit keep_en, input bit perturb, input string tag,
                         output longint ack_at);
    int first_ack = 0;
    int n_ack     = 0;
    int n_busy    = 0;
    int idx       = line_of(addr);
    ack_at = -1;
    check({tag, "_busy_pre"}, bus.busy_o, 1'b0);
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = addr;
    bus.data_i   = data;
    for (int c = 1; c <= L + 1; c++) begin
      tick();
      if (bus.ack_o === 1'b1) begin
        n_ack++;
        if (first_ack == 0) begin
          first_ack = c;
          ack_at    = cyc;
        end
      end
      if (bus.busy_o === 1'b1) n_busy++;
      if (perturb && c == 3) begin
        bus.addr_i   = ~addr;
        bus.data_i   = ~data;
        bus.write_i  = ~wr;
        bus.enable_i = 1'b0;
      end
    end
    check({tag, "_ack_cycle"}, first_ack, L + 1);
    check({tag, "_ack_count"}, n_ack, 1);
    check({tag, "_busy_cycles"}, n_busy, L + 1);
    if (wr) begin
      model[idx] = data;
    end else begin
      last_rd = model.exists(idx) ? model[idx] : 'x;
    end
    check({tag, "_data_o"}, bus.data_o, last_rd);
    if (!keep_en) bus.enable_i = 1'b0;
    tick();
    check({tag, "_ack_post"}, bus.ack_o, 1'b0);
  endtask

  initial begin
    longint a1, a2, dummy;
    logic [255:0] d0, d1, d2, d3, d4, d5, da5;
    int acks;

    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    d0 = rand_line(); d1 = rand_line(); d2 = rand_line();
    d3 = rand_line(); d4 = rand_line(); d5 = rand_line();
    da5 = {32{8'hA5}};

    // Reset held for three cycles, then a quiet bus.
    repeat (3) tick();
    check("rst_ack", bus.ack_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_data", bus.data_o, '0);
    rst_i = 1'b1;
    idle(20, "quiet_no_ack");
    check("quiet_busy", bus.busy_o, 1'b0);

    // Write then read the same line.
    run_req(1'b1, 32'h0000_0040, da5, 1'b0, 1'b0, "wr_a5", dummy);
    idle(2, "gap1");
    run_req(1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, "rd_a5", dummy);
    check("rd_a5_value", bus.data_o, da5);

    // Write-back followed by refill with enable held high throughout.
    run_req(1'b1, 32'h0000_0800, d5, 1'b0, 1'b0, "pre_800", dummy);
    run_req(1'b1, 32'h0000_0400, d1, 1'b1, 1'b0, "wb", a1);
    run_req(1'b0, 32'h0000_0800, '0, 1'b0, 1'b0, "refill", a2);
    check("b2b_ack_spacing", a2 - a1, L + 2);
    idle(3, "gap2");
    run_req(1'b0, 32'h0000_0400, '0, 1'b0, 1'b0, "rd_400", dummy);

    // Inputs changed and enable dropped during BUSY.
    run_req(1'b1, 32'h0000_3F80, d5, 1'b0, 1'b0, "pre_line508", dummy);
    run_req(1'b1, 32'h0000_0060, d4, 1'b0, 1'b1, "perturb", dummy);
    idle(1, "gap3");
    run_req(1'b0, 32'h0000_0060, '0, 1'b0, 1'b0, "rd_captured", dummy);
    run_req(1'b0, 32'h0000_3F80, '0, 1'b0, 1'b0, "rd_untouched", dummy);

    // Offset bits and bits above the index are ignored.
    run_req(1'b1, 32'h0000_0020, d2, 1'b0, 1'b0, "wr_alias", dummy);
    run_req(1'b0, 32'h0000_403F, '0, 1'b0, 1'b0, "rd_alias", dummy);
    check("alias_value", bus.data_o, d2);

    // Reset in cycle 5 of a write discards it.
    run_req(1'b1, 32'h0000_00A0, d0, 1'b0, 1'b0, "wr_idx5_old", dummy);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_00A0;
    bus.data_i   = d3;
    acks = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (bus.ack_o === 1'b1) acks++;
    end
    rst_i = 1'b0;
    #1;
    check("midrst_busy", bus.busy_o, 1'b0);
    check("midrst_data", bus.data_o, '0);
    bus.enable_i = 1'b0;
    last_rd = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.ack_o === 1'b1) acks++;
    end
    rst_i = 1'b1;
    for (int c = 0; c < L + 4; c++) begin
      tick();
      if (bus.ack_o === 1'b1) acks++;
    end
    check("midrst_no_ack", acks, 0);
    run_req(1'b0, 32'h0000_00A0, '0, 1'b0, 1'b0, "rd_idx5", dummy);
    check("idx5_retained", bus.data_o, d0);

    // Randomized traffic over a handful of lines with aliased addresses.
    for (int i = 0; i < 40; i++) begin
      int          line = $urandom_range(0, 7) * 37;
      logic [31:0] addr = ($urandom & 32'hFFFF_C01F) | (32'(line) << 5);
      logic        wr   = !model.exists(line_of(addr)) || ($urandom_range(0, 1) == 1);
      bit          keep = (i != 39) && ($urandom_range(0, 1) == 1);
      bit          pert = ($urandom_range(0, 3) == 0);
      if (pert && model.exists(line_of(~addr)) == 0 && wr == 1'b0) pert = 1'b0;
      run_req(wr, addr, rand_line(), keep, pert, $sformatf("rnd%0d", i), dummy);
      if (!keep) idle($urandom_range(0, 3), $sformatf("rnd%0d_gap", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
